// File: rtl/btn_cond_pkg.sv
// Shared types and sizing helpers for the push-button input conditioner.
package btn_cond_pkg;

  typedef enum logic [1:0] {
    RELEASED    = 2'd0,
    PRESS_CHK   = 2'd1,
    HELD        = 2'd2,
    RELEASE_CHK = 2'd3
  } btn_state_t;

  // Width of a counter that must reach the larger of the debounce and repeat periods.
  function automatic int cnt_width(input int deb_cycles, input int rpt_cycles);
    int m;
    m = (deb_cycles > rpt_cycles) ? deb_cycles : rpt_cycles;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/btn_cond_debounce.sv
// One button: synchroniser, debounce FSM and registered single-cycle press pulse.
// Optional auto-repeat while held when BTN_COND_AUTO_REPEAT_EN is defined (per-instance rpt_en tie).
module btn_debounce
  import btn_cond_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_CYCLES   = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  input  logic rpt_en,
  output logic pulse,
  output logic pulse_set
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES, REPEAT_CYCLES);
  localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  btn_state_t             state_q, state_d, prev_q;
  logic [CW-1:0]          cnt_q, cnt_d, cnt_inc;
  logic                   entry;

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
    end
  end

  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      RELEASED: begin
        if (s) begin
          state_d = PRESS_CHK;
          cnt_d   = '0;
        end
      end
      PRESS_CHK: begin
        if (!s) begin
          state_d = RELEASED;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_q == DEB_LAST) state_d = HELD;
        end
      end
      HELD: begin
        if (!s) begin
          state_d = RELEASE_CHK;
          cnt_d   = '0;
        end
      end
      RELEASE_CHK: begin
        if (s) begin
          state_d = HELD;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_q == DEB_LAST) state_d = RELEASED;
        end
      end
      default: state_d = RELEASED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RELEASED;
      prev_q  <= RELEASED;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      prev_q  <= state_q;
      cnt_q   <= cnt_d;
    end
  end

  // Only a debounced press (not a release-bounce recovery) counts as a fresh entry.
  assign entry = (state_q == HELD) && (prev_q == PRESS_CHK);

`ifdef BTN_COND_AUTO_REPEAT_EN
  localparam logic [CW-1:0] RPT_LAST = CW'(REPEAT_CYCLES - 1);

  logic [CW-1:0] rpt_q;
  logic          rpt_fire;

  assign rpt_fire  = rpt_en && (state_q == HELD) && !entry && (rpt_q == RPT_LAST);
  assign pulse_set = entry || rpt_fire;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rpt_q <= '0;
    end else if ((state_q != HELD) || entry || rpt_fire) begin
      rpt_q <= '0;
    end else if (rpt_q != '1) begin
      rpt_q <= rpt_q + 1'b1;
    end
  end
`else
  logic unused_rpt_en;
  assign unused_rpt_en = rpt_en;
  assign pulse_set     = entry;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pulse <= 1'b0;
    end else begin
      pulse <= pulse_set;
    end
  end

endmodule

// File: rtl/btn_cond.sv
// Conditions two raw buttons and an 8-bit switch bank into ld/inc pulses plus a held load value.
// Auto-repeat on the inc button is enabled by defining BTN_COND_AUTO_REPEAT_EN.
module btn_cond
  import btn_cond_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_CYCLES   = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_ld_raw,
  input  logic       btn_inc_raw,
  input  logic [7:0] sw_raw,
  output logic       ld,
  output logic       inc,
  output logic [7:0] in
);

  logic [7:0] sw_sync_q [SYNC_STAGES];
  logic       ld_set;
  logic       unused_inc_set;

  btn_debounce #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_CYCLES  (REPEAT_CYCLES)
  ) u_ld (
    .clk      (clk),
    .rst_n    (rst_n),
    .raw      (btn_ld_raw),
    .rpt_en   (1'b0),
    .pulse    (ld),
    .pulse_set(ld_set)
  );

  btn_debounce #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_CYCLES  (REPEAT_CYCLES)
  ) u_inc (
    .clk      (clk),
    .rst_n    (rst_n),
    .raw      (btn_inc_raw),
    .rpt_en   (1'b1),
    .pulse    (inc),
    .pulse_set(unused_inc_set)
  );

  // The load value is captured on the same edge that raises ld, so it is valid with the pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sw_sync_q[i] <= '0;
      in <= '0;
    end else begin
      sw_sync_q[0] <= sw_raw;
      for (int i = 1; i < SYNC_STAGES; i++) sw_sync_q[i] <= sw_sync_q[i-1];
      if (ld_set) in <= sw_sync_q[SYNC_STAGES-1];
    end
  end

endmodule

// File: tb/tb_btn_cond.sv
// Directed bench for btn_cond with SYNC_STAGES=2, DEBOUNCE_CYCLES=4, REPEAT_CYCLES=8.
module tb_btn_cond;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       btn_ld_raw;
  logic       btn_inc_raw;
  logic [7:0] sw_raw;
  logic       ld;
  logic       inc;
  logic [7:0] in;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int ld_cnt   = 0;
  int inc_cnt  = 0;
  int ld_last  = -1;
  int c0;
  int inc_hist[$];

  btn_cond #(
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4),
    .REPEAT_CYCLES  (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_ld_raw (btn_ld_raw),
    .btn_inc_raw(btn_inc_raw),
    .sw_raw     (sw_raw),
    .ld         (ld),
    .inc        (inc),
    .in         (in)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cyc++;
      if (ld === 1'b1) begin
        ld_cnt++;
        ld_last = cyc;
      end
      if (inc === 1'b1) begin
        inc_cnt++;
        inc_hist.push_back(cyc);
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    // 1: reset with both buttons held
    rst_n = 1'b0; btn_ld_raw = 1'b1; btn_inc_raw = 1'b1; sw_raw = 8'h00;
    step(3);
    chk("rst_ld", {31'd0, ld}, 32'd0);
    chk("rst_inc", {31'd0, inc}, 32'd0);
    chk("rst_in", {24'd0, in}, 32'h00);
    rst_n = 1'b1; c0 = cyc; ld_cnt = 0; inc_cnt = 0;
    step(7);
    chk("rst_no_early_ld", {31'd0, ld}, 32'd0);
    step(1);
    chk("rst_ld_pulse", {31'd0, ld}, 32'd1);
    chk("rst_inc_pulse", {31'd0, inc}, 32'd1);
    chk("rst_ld_latency", ld_last - c0, 32'd8);
    btn_ld_raw = 1'b0; btn_inc_raw = 1'b0;
    step(20);
    chk("rst_ld_count", ld_cnt, 32'd1);
    chk("rst_inc_count", inc_cnt, 32'd1);

    // 2: clean inc press held 20 cycles
    inc_cnt = 0; btn_inc_raw = 1'b1;
    step(7);
    chk("clean_inc_early", {31'd0, inc}, 32'd0);
    step(1);
    chk("clean_inc_pulse", {31'd0, inc}, 32'd1);
    step(1);
    chk("clean_inc_single", {31'd0, inc}, 32'd0);
    step(11);
    btn_inc_raw = 1'b0;
    step(12);
`ifdef BTN_COND_AUTO_REPEAT_EN
    chk("clean_inc_count", inc_cnt, 32'd2);
`else
    chk("clean_inc_count", inc_cnt, 32'd1);
`endif

    // 3: bouncing ld press with switches A5, then switches change
    ld_cnt = 0; sw_raw = 8'hA5; btn_ld_raw = 1'b1;
    step(3);
    btn_ld_raw = 1'b0;
    step(1);
    btn_ld_raw = 1'b1;
    step(7);
    chk("bounce_no_early", ld_cnt, 32'd0);
    chk("bounce_in_hold", {24'd0, in}, 32'h00);
    step(1);
    chk("bounce_ld_pulse", {31'd0, ld}, 32'd1);
    chk("bounce_in_load", {24'd0, in}, 32'hA5);
    sw_raw = 8'h3C;
    step(10);
    chk("bounce_in_keep", {24'd0, in}, 32'hA5);
    chk("bounce_ld_count", ld_cnt, 32'd1);

    // 4: release bounce, then a real release and re-press
    ld_cnt = 0; btn_ld_raw = 1'b0;
    step(2);
    btn_ld_raw = 1'b1;
    step(15);
    chk("relbounce_no_pulse", ld_cnt, 32'd0);
    btn_ld_raw = 1'b0;
    step(10);
    btn_ld_raw = 1'b1;
    step(7);
    chk("repress_early", {31'd0, ld}, 32'd0);
    step(1);
    chk("repress_pulse", {31'd0, ld}, 32'd1);
    chk("repress_in", {24'd0, in}, 32'h3C);
    btn_ld_raw = 1'b0;
    step(12);
    chk("repress_count", ld_cnt, 32'd1);

    // 5: both buttons rise together
    btn_ld_raw = 1'b1; btn_inc_raw = 1'b1;
    step(7);
    chk("simul_early", {30'd0, ld, inc}, 32'd0);
    step(1);
    chk("simul_pulse", {30'd0, ld, inc}, 32'd3);
    btn_ld_raw = 1'b0; btn_inc_raw = 1'b0;
    step(12);

`ifdef BTN_COND_AUTO_REPEAT_EN
    // 6: auto-repeat while inc held, then reset mid-hold
    inc_cnt = 0; inc_hist.delete(); btn_inc_raw = 1'b1;
    step(8);
    chk("rpt_first", {31'd0, inc}, 32'd1);
    step(26);
    btn_inc_raw = 1'b0;
    step(12);
    chk("rpt_count", inc_cnt, 32'd4);
    if (inc_hist.size() >= 4) begin
      chk("rpt_gap1", inc_hist[1] - inc_hist[0], 32'd8);
      chk("rpt_gap3", inc_hist[3] - inc_hist[2], 32'd8);
    end
    btn_inc_raw = 1'b1;
    step(8);
    chk("rpt_rst_first", {31'd0, inc}, 32'd1);
    step(7);
    rst_n = 1'b0; inc_cnt = 0;
    step(1);
    chk("rpt_rst_stop", {31'd0, inc}, 32'd0);
    step(10);
    chk("rpt_rst_quiet", inc_cnt, 32'd0);
    btn_inc_raw = 1'b0; rst_n = 1'b1;
    step(5);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
